// File: rtl/task_scheduler_if.sv
// rtl/task_scheduler_if.sv - host command stream and per-unit start/ready handshakes
interface task_scheduler_if;
  logic        cmd_valid;
  logic [63:0] cmd_data;
  logic        cmd_ready;
  logic        core0_start;
  logic        core1_start;
  logic        dma_start;
  logic        core0_ready;
  logic        core1_ready;
  logic        dma_ready;

  modport master (
    output cmd_valid, cmd_data, core0_ready, core1_ready, dma_ready,
    input  cmd_ready, core0_start, core1_start, dma_start
  );

  modport slave (
    input  cmd_valid, cmd_data, core0_ready, core1_ready, dma_ready,
    output cmd_ready, core0_start, core1_start, dma_start
  );
endinterface

// File: rtl/task_scheduler.sv
// rtl/task_scheduler.sv - in-order command FIFO dispatching to two NTT cores and a DMA with bank hazard checks
// Optional macro SCHED_PERF_CNT_EN builds the saturating stall_cycles counter.
module task_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_BANKS  = 4
) (
  input  logic            clk,
  input  logic            rst,
  task_scheduler_if.slave bus,
  output logic            halted,
  output logic [31:0]     stall_cycles
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 4 + NUM_BANKS;
  localparam logic [3:0] OP_NTT   = 4'h1;
  localparam logic [3:0] OP_DMA   = 4'h2;
  localparam logic [3:0] OP_FENCE = 4'h3;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {IDLE, LAUNCHED, RUNNING} trk_state_t;

  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count, count_next;
  logic [EW-1:0]        head_entry;
  logic [3:0]           head_op;
  logic [NUM_BANKS-1:0] head_mask, busy_mask;
  logic                 push, pop, head_valid, all_idle, halt_retire, halted_next;
  logic [2:0]           unit_ready, unit_free, launch;
  trk_state_t           trk_state [3];
  trk_state_t           trk_next  [3];
  logic [NUM_BANKS-1:0] trk_mask      [3];
  logic [NUM_BANKS-1:0] trk_mask_next [3];
  logic                 unused_cmd_bits;

  assign unused_cmd_bits = ^bus.cmd_data[55:0];
  assign unit_ready  = {bus.dma_ready, bus.core1_ready, bus.core0_ready};
  assign head_entry  = fifo_mem[rd_ptr];
  assign head_op     = head_entry[EW-1 -: 4];
  assign head_mask   = head_entry[NUM_BANKS-1:0];
  assign head_valid  = (count != '0) && !halted;
  assign push        = bus.cmd_valid && bus.cmd_ready;
  assign count_next  = count + CW'(push) - CW'(pop);
  assign halted_next = halted | halt_retire;

  // Trackers are registered, so a unit finishing this cycle only frees its banks next cycle.
  always_comb begin
    busy_mask = '0;
    all_idle  = 1'b1;
    unit_free = '0;
    for (int u = 0; u < 3; u++) begin
      unit_free[u] = (trk_state[u] == IDLE) && unit_ready[u];
      if (trk_state[u] != IDLE) begin
        busy_mask = busy_mask | trk_mask[u];
        all_idle  = 1'b0;
      end
    end
  end

  always_comb begin
    pop         = 1'b0;
    launch      = '0;
    halt_retire = 1'b0;
    if (head_valid) begin
      case (head_op)
        OP_NTT: begin
          if ((head_mask & busy_mask) == '0) begin
            if (unit_free[0]) begin
              launch[0] = 1'b1;
              pop       = 1'b1;
            end else if (unit_free[1]) begin
              launch[1] = 1'b1;
              pop       = 1'b1;
            end
          end
        end
        OP_DMA: begin
          if (((head_mask & busy_mask) == '0) && unit_free[2]) begin
            launch[2] = 1'b1;
            pop       = 1'b1;
          end
        end
        OP_FENCE: pop = all_idle;
        OP_HALT: begin
          pop         = all_idle;
          halt_retire = all_idle;
        end
        default: pop = 1'b1;
      endcase
    end
  end

  always_comb begin
    for (int u = 0; u < 3; u++) begin
      trk_next[u]      = trk_state[u];
      trk_mask_next[u] = trk_mask[u];
      case (trk_state[u])
        IDLE: begin
          if (launch[u]) begin
            trk_next[u]      = LAUNCHED;
            trk_mask_next[u] = head_mask;
          end
        end
        LAUNCHED: if (!unit_ready[u]) trk_next[u] = RUNNING;
        RUNNING: begin
          if (unit_ready[u]) begin
            trk_next[u]      = IDLE;
            trk_mask_next[u] = '0;
          end
        end
        default: begin
          trk_next[u]      = IDLE;
          trk_mask_next[u] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.cmd_data[63:60], bus.cmd_data[56 +: NUM_BANKS]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      bus.cmd_ready   <= 1'b1;
      halted          <= 1'b0;
      bus.core0_start <= 1'b0;
      bus.core1_start <= 1'b0;
      bus.dma_start   <= 1'b0;
      for (int u = 0; u < 3; u++) begin
        trk_state[u] <= IDLE;
        trk_mask[u]  <= '0;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count           <= count_next;
      halted          <= halted_next;
      bus.cmd_ready   <= !halted_next && (count_next != CW'(FIFO_DEPTH));
      bus.core0_start <= launch[0];
      bus.core1_start <= launch[1];
      bus.dma_start   <= launch[2];
      for (int u = 0; u < 3; u++) begin
        trk_state[u] <= trk_next[u];
        trk_mask[u]  <= trk_mask_next[u];
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (head_valid && !pop && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_task_scheduler.sv
// tb/tb_task_scheduler.sv - directed and randomized checks of task_scheduler against a queue-based model
module tb_task_scheduler;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_LAUNCHED = 1, M_RUNNING = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [31:0] stall_cycles;
  logic        cmd_valid = 1'b0;
  logic [63:0] cmd_data = '0;
  logic        auto_units = 1'b0;
  logic [2:0]  man_rdy = 3'b111;
  logic [2:0]  auto_rdy = 3'b111;
  int          vectors = 0;
  int          miscompares = 0;

  task_scheduler_if bus();

  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_data  = cmd_data;
  assign {bus.dma_ready, bus.core1_ready, bus.core0_ready} = auto_units ? auto_rdy : man_rdy;

  task_scheduler #(.FIFO_DEPTH(DEPTH), .NUM_BANKS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a command queue plus a per-unit state and mask, advanced once per clock.
  logic [63:0] q[$];
  int          u_state [3];
  logic [3:0]  u_mask  [3];
  logic [2:0]  m_start;
  logic        m_halted, m_ready, m_live = 1'b0;
  logic [31:0] m_stall;

  always @(posedge clk) begin : model_step
    logic [2:0] rdy;
    logic [3:0] busy, op, mk;
    logic       pop, all_idle, halt_now;
    int         pick;
    rdy = {bus.dma_ready, bus.core1_ready, bus.core0_ready};
    m_live = 1'b1;
    if (rst) begin
      q.delete();
      for (int u = 0; u < 3; u++) begin u_state[u] = M_IDLE; u_mask[u] = 4'h0; end
      m_start = 3'b000; m_halted = 1'b0; m_ready = 1'b1; m_stall = 32'd0;
    end else begin
      busy = 4'h0; all_idle = 1'b1; pick = -1; pop = 1'b0; halt_now = 1'b0; mk = 4'h0;
      for (int u = 0; u < 3; u++)
        if (u_state[u] != M_IDLE) begin busy |= u_mask[u]; all_idle = 1'b0; end
      if (q.size() != 0 && !m_halted) begin
        op = q[0][63:60];
        mk = q[0][59:56];
        if (op == 4'h1) begin
          if ((mk & busy) == 4'h0) begin
            if (u_state[0] == M_IDLE && rdy[0]) pick = 0;
            else if (u_state[1] == M_IDLE && rdy[1]) pick = 1;
          end
        end else if (op == 4'h2) begin
          if ((mk & busy) == 4'h0 && u_state[2] == M_IDLE && rdy[2]) pick = 2;
        end else if (op == 4'h3 || op == 4'hF) begin
          pop = all_idle;
          halt_now = all_idle && (op == 4'hF);
        end else begin
          pop = 1'b1;
        end
        if (pick >= 0) pop = 1'b1;
      end
      if (q.size() != 0 && !m_halted && !pop && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      for (int u = 0; u < 3; u++) begin
        if (u_state[u] == M_LAUNCHED && !rdy[u]) u_state[u] = M_RUNNING;
        else if (u_state[u] == M_RUNNING && rdy[u]) begin u_state[u] = M_IDLE; u_mask[u] = 4'h0; end
      end
      m_start = 3'b000;
      if (pick >= 0) begin u_state[pick] = M_LAUNCHED; u_mask[pick] = mk; m_start[pick] = 1'b1; end
      if (pop) q.delete(0);
      if (cmd_valid && m_ready) q.push_back(cmd_data);
      m_halted = m_halted | halt_now;
      m_ready  = !m_halted && (q.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("core0_start", bus.core0_start, m_start[0]);
      chk("core1_start", bus.core1_start, m_start[1]);
      chk("dma_start", bus.dma_start, m_start[2]);
      chk("cmd_ready", bus.cmd_ready, m_ready);
      chk("halted", halted, m_halted);
`ifdef SCHED_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
`else
      chk("stall_cycles", stall_cycles, 64'd0);
`endif
    end
  end

  // Simple unit behaviour: busy for a random time after each start, occasionally not ready while idle.
  int busy_cnt [3] = '{0, 0, 0};
  always @(negedge clk) begin : unit_sim
    logic [2:0] st;
    st = {bus.dma_start, bus.core1_start, bus.core0_start};
    for (int u = 0; u < 3; u++) begin
      if (rst) begin
        busy_cnt[u] = 0; auto_rdy[u] = 1'b1;
      end else if (st[u]) begin
        busy_cnt[u] = $urandom_range(1, 6); auto_rdy[u] = 1'b0;
      end else begin
        if (busy_cnt[u] > 0) busy_cnt[u]--;
        auto_rdy[u] = (busy_cnt[u] == 0) && ($urandom_range(0, 7) != 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] mk);
    cmd_valid = 1'b1;
    cmd_data  = {op, mk, 56'($urandom)};
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    auto_units = 1'b0;
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int n_core, n_dma;
    logic [3:0] rop;
    int r;

    // Two NTTs on disjoint banks go to core 0 then core 1 on consecutive cycles.
    do_reset(); man_rdy = 3'b111;
    chk("rst cmd_ready", bus.cmd_ready, 1);
    chk("rst halted", halted, 0);
    chk("rst starts", {bus.dma_start, bus.core1_start, bus.core0_start}, 0);
    chk("rst stall", stall_cycles, 0);
    send(4'h1, 4'b0001);
    send(4'h1, 4'b0010);
    chk("A core0_start", bus.core0_start, 1);
    chk("A core1_idle", bus.core1_start, 0);
    tick();
    chk("A core1_start", bus.core1_start, 1);
    chk("A core0_done", bus.core0_start, 0);
    man_rdy = 3'b100; tick(2);
    man_rdy = 3'b111;
    send(4'h1, 4'b0000);
    tick();
    chk("A core0_reuse", bus.core0_start, 1);

    // DMA on core 0's bank waits for core 0 to finish.
    do_reset(); man_rdy = 3'b111;
    send(4'h1, 4'b0001);
    send(4'h2, 4'b0001);
    chk("B core0_start", bus.core0_start, 1);
    man_rdy[0] = 1'b0;
    repeat (4) begin tick(); chk("B dma_blocked", bus.dma_start, 0); end
    man_rdy[0] = 1'b1;
    tick(); chk("B dma_not_yet", bus.dma_start, 0);
    tick(); chk("B dma_start", bus.dma_start, 1);
`ifdef SCHED_PERF_CNT_EN
    chk("B stall_cycles", stall_cycles, 5);
`endif

    // FIFO fill with all units busy, then drain in order.
    do_reset(); man_rdy = 3'b000;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = {((i % 2) == 0) ? 4'h1 : 4'h2, 4'h0, 56'(i)};
      tick();
    end
    chk("C ready_full", bus.cmd_ready, 0);
    cmd_data = {4'h1, 4'h0, 56'd4};
    tick(); chk("C still_full", bus.cmd_ready, 0);
    man_rdy[0] = 1'b1;
    tick(); chk("C first_deq", bus.core0_start, 1); chk("C ready_back", bus.cmd_ready, 1);
    man_rdy[0] = 1'b0;
    tick(); chk("C fifth_taken", bus.cmd_ready, 0);
    cmd_valid = 1'b0;
    auto_units = 1'b1;
    n_core = 0; n_dma = 0;
    repeat (60) begin
      tick();
      n_core += int'(bus.core0_start) + int'(bus.core1_start);
      n_dma  += int'(bus.dma_start);
    end
    chk("C core_starts", n_core, 2);
    chk("C dma_starts", n_dma, 2);
    chk("C drained", bus.cmd_ready, 1);

    // FENCE holds a disjoint DMA until the core is idle.
    do_reset(); man_rdy = 3'b111;
    send(4'h1, 4'b0001);
    send(4'h3, 4'b0000);
    chk("D core0_start", bus.core0_start, 1);
    man_rdy[0] = 1'b0;
    send(4'h2, 4'b0100);
    chk("D dma_fenced", bus.dma_start, 0);
    tick(); chk("D dma_fenced", bus.dma_start, 0);
    tick(); chk("D dma_fenced", bus.dma_start, 0);
    man_rdy[0] = 1'b1;
    tick(); chk("D fence_retire", bus.dma_start, 0);
    tick(); chk("D dma_decide", bus.dma_start, 0);
    tick(); chk("D dma_start", bus.dma_start, 1);

    // HALT waits for idle, then freezes everything.
    do_reset(); man_rdy = 3'b111;
    send(4'h1, 4'b0001);
    send(4'hF, 4'b0000);
    man_rdy[0] = 1'b0;
    send(4'h2, 4'b0010);
    send(4'h1, 4'b0100);
    chk("E not_halted", halted, 0);
    tick(); chk("E not_halted", halted, 0);
    man_rdy[0] = 1'b1;
    tick(); chk("E not_halted", halted, 0);
    tick(); chk("E halted", halted, 1); chk("E ready_low", bus.cmd_ready, 0);
    cmd_valid = 1'b1; cmd_data = {4'h2, 4'h0, 56'd0};
    repeat (5) begin
      tick();
      chk("E halted_sticky", halted, 1);
      chk("E ready_low", bus.cmd_ready, 0);
      chk("E no_starts", {bus.dma_start, bus.core1_start, bus.core0_start}, 0);
    end
    cmd_valid = 1'b0;

    // Reset while core 1 runs and three entries are queued.
    do_reset(); man_rdy = 3'b111;
    send(4'h1, 4'b0001);
    man_rdy = 3'b010;
    send(4'h1, 4'b0010);
    man_rdy = 3'b000;
    send(4'h2, 4'b0000);
    send(4'h2, 4'b0000);
    send(4'h2, 4'b0000);
    rst = 1'b1;
    tick();
    chk("F cmd_ready", bus.cmd_ready, 1);
    chk("F starts", {bus.dma_start, bus.core1_start, bus.core0_start}, 0);
    chk("F halted", halted, 0);
    chk("F stall", stall_cycles, 0);
    rst = 1'b0; man_rdy = 3'b111;
    repeat (4) begin tick(); chk("F fifo_empty", {bus.dma_start, bus.core1_start, bus.core0_start}, 0); end

    // Randomized traffic with occasional resets.
    do_reset(); auto_units = 1'b1;
    repeat (1500) begin
      rst = ($urandom_range(0, 99) == 0);
      cmd_valid = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      if (r < 30)      rop = 4'h1;
      else if (r < 55) rop = 4'h2;
      else if (r < 65) rop = 4'h3;
      else if (r < 75) rop = 4'h0;
      else if (r < 98) rop = 4'($urandom_range(4, 14));
      else             rop = 4'hF;
      cmd_data = {rop, 4'($urandom_range(0, 15)), 56'($urandom)};
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
